// File: rtl/ara_runtime_profiler.sv
// rtl/ara_runtime_profiler.sv - Ara vector-runtime window sequencer with {cycles, instrs} record FIFO
// Measures SW-gated runtime windows, snapshots runtime at quiescent points, and queues one record per window.
module ara_runtime_profiler #(
    parameter int unsigned CntWidth  = 64,
    parameter int unsigned InsnWidth = 32,
    parameter int unsigned NrRecords = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           sw_en_i,
    input  logic                           clr_i,
    input  logic                           acc_req_valid_i,
    input  logic                           acc_req_ready_i,
    input  logic                           ara_idle_i,
    output logic                           busy_o,
    output logic [CntWidth-1:0]            runtime_o,
    output logic                           rec_valid_o,
    input  logic                           rec_ready_i,
    output logic [CntWidth-1:0]            rec_cycles_o,
    output logic [InsnWidth-1:0]           rec_insns_o,
    output logic [$clog2(NrRecords+1)-1:0] nr_rec_o,
    output logic                           overflow_o
);
    localparam int unsigned PtrW = $clog2(NrRecords);
    localparam int unsigned NrW  = $clog2(NrRecords+1);
    localparam logic [CntWidth-1:0]  CntOne  = 1;
    localparam logic [InsnWidth-1:0] InsnOne = 1;
    localparam logic [PtrW-1:0]      PtrOne  = 1;
    localparam logic [NrW-1:0]       NrOne   = 1;
    localparam logic [NrW-1:0]       NrFull  = NrW'(NrRecords);

    typedef enum logic [1:0] {IDLE, ARMED, RUNNING, DRAIN} state_e;

    state_e               state_q, state_d;
    logic [CntWidth-1:0]  cyc_q, cyc_d, runtime_q, runtime_d, cyc_inc;
    logic [InsnWidth-1:0] insn_q, insn_d, insn_inc;
    logic                 dispatch, quiet, push, pop, full, wr_en;
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [NrW-1:0]       cnt_q;
    logic                 ovf_q;
    logic [CntWidth-1:0]  mem_cyc_q  [NrRecords];
    logic [InsnWidth-1:0] mem_insn_q [NrRecords];

    assign dispatch = acc_req_valid_i & acc_req_ready_i;
    assign quiet    = ara_idle_i & ~acc_req_valid_i;
    assign cyc_inc  = (&cyc_q) ? cyc_q : cyc_q + CntOne;
    assign insn_inc = (dispatch && !(&insn_q)) ? insn_q + InsnOne : insn_q;

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        insn_d    = insn_q;
        runtime_d = runtime_q;
        push      = 1'b0;
        case (state_q)
            IDLE: if (sw_en_i) state_d = ARMED;
            ARMED: begin
                if (!sw_en_i) begin
                    state_d = IDLE;
                end else if (acc_req_valid_i) begin
                    state_d = RUNNING;
                    cyc_d   = CntOne;
                    insn_d  = dispatch ? InsnOne : '0;
                end
            end
            RUNNING: begin
                cyc_d  = cyc_inc;
                insn_d = insn_inc;
                if (quiet)    runtime_d = cyc_q;
                if (!sw_en_i) state_d   = DRAIN;
            end
            DRAIN: begin
                cyc_d  = cyc_inc;
                insn_d = insn_inc;
                if (quiet) begin
                    runtime_d = cyc_q;
                    push      = 1'b1;
                    state_d   = sw_en_i ? ARMED : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Clear discards the open window; the snapshot register is deliberately kept.
        if (clr_i) begin
            state_d = IDLE;
            cyc_d   = '0;
            insn_d  = '0;
            push    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            insn_q    <= '0;
            runtime_q <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            insn_q    <= insn_d;
            runtime_q <= runtime_d;
        end
    end

    // A push into a full FIFO survives only if the head leaves in the same cycle.
    assign full  = (cnt_q == NrFull);
    assign pop   = rec_ready_i & (cnt_q != '0) & ~clr_i;
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)   rd_ptr_q <= rd_ptr_q + PtrOne;
            if (wr_en && !pop)      cnt_q <= cnt_q + NrOne;
            else if (!wr_en && pop) cnt_q <= cnt_q - NrOne;
            if (push && !wr_en) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_cyc_q[wr_ptr_q]  <= cyc_q;
            mem_insn_q[wr_ptr_q] <= insn_q;
        end
    end

    assign busy_o       = (state_q == RUNNING) || (state_q == DRAIN);
    assign runtime_o    = runtime_q;
    assign rec_valid_o  = (cnt_q != '0);
    assign rec_cycles_o = rec_valid_o ? mem_cyc_q[rd_ptr_q] : '0;
    assign rec_insns_o  = rec_valid_o ? mem_insn_q[rd_ptr_q] : '0;
    assign nr_rec_o     = cnt_q;
    assign overflow_o   = ovf_q;
endmodule
